// File: rtl/auth_defs_pkg.sv
// Shared codes and FSM encoding for the authentication responder.
package auth_defs;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_ENGINE = 2'd1,
        SEND_RESP   = 2'd2,
        SEND_ERR    = 2'd3
    } state_e;

    localparam logic [7:0] REQ_GET_DIGESTS     = 8'h81;
    localparam logic [7:0] REQ_GET_CERTIFICATE = 8'h82;
    localparam logic [7:0] REQ_CHALLENGE       = 8'h83;
    localparam logic [7:0] RESP_ERROR          = 8'h7F;
    localparam logic [7:0] ERR_INVALID         = 8'h01;
    localparam logic [7:0] ERR_BUSY            = 8'h03;

    function automatic logic is_engine_req(input logic [7:0] code);
        return (code == REQ_GET_DIGESTS) || (code == REQ_GET_CERTIFICATE) ||
               (code == REQ_CHALLENGE);
    endfunction

endpackage

// File: rtl/auth_responder_deadline_if.sv
// Request / engine / transmit signal bundle. tx_valid/tx_ready: a message moves on a
// cycle where both are 1; while tx_valid=1 and tx_ready=0 the payload is held stable.
interface auth_responder_deadline_if
    import auth_defs::*;
#(
    parameter int CNT_W = 32
);
    logic             req_valid;
    logic [7:0]       req_type;
    logic [CNT_W-1:0] resp_deadline;
    logic             engine_start;
    logic             engine_done;
    logic [7:0]       engine_resp_type;
    logic             engine_abort;
    logic             tx_valid;
    logic             tx_ready;
    logic [7:0]       tx_type;
    logic [7:0]       tx_err_code;
    logic             busy;
    logic [7:0]       drop_count;
    state_e           state_dbg;

    modport master (
        output req_valid, req_type, resp_deadline, engine_done, engine_resp_type, tx_ready,
        input  engine_start, engine_abort, tx_valid, tx_type, tx_err_code, busy,
        input  drop_count, state_dbg
    );

    modport slave (
        input  req_valid, req_type, resp_deadline, engine_done, engine_resp_type, tx_ready,
        output engine_start, engine_abort, tx_valid, tx_type, tx_err_code, busy,
        output drop_count, state_dbg
    );
endinterface

// File: rtl/deadline_counter.sv
// Cycle counter with a one-bit-wider expiry compare so an all-ones limit never wraps.
module deadline_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cnt_inc;

    always_comb begin
        cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        cnt_d   = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_inc[CNT_W-1:0];
        end
        expired = enable && (cnt_inc >= {1'b0, limit});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/auth_responder_deadline.sv
// Authentication responder: forwards valid requests to the crypto engine and replies
// BUSY if the engine misses the sampled deadline; every output is a flop.
module auth_responder_deadline
    import auth_defs::*;
#(
    parameter int CNT_W = 32
) (
    input logic                      clk,
    input logic                      reset_n,
    auth_responder_deadline_if.slave bus
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [7:0]       resp_code_q, resp_code_d;
    logic [7:0]       err_code_q, err_code_d;
    logic             engine_start_q, engine_start_d;
    logic             engine_abort_q, engine_abort_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       tx_type_q, tx_type_d;
    logic [7:0]       tx_err_code_q, tx_err_code_d;
    logic             busy_q, busy_d;
    logic [7:0]       drop_count_q, drop_count_d;
    logic             ctr_clear, ctr_en, expired;

    // The engine_start cycle is not counted, which puts the first BUSY tx_valid D+1 cycles after it.
    assign ctr_en = (state_q == WAIT_ENGINE) && !engine_start_q;

    deadline_counter #(.CNT_W(CNT_W)) u_deadline (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (ctr_clear),
        .enable  (ctr_en),
        .limit   (limit_q),
        .expired (expired)
    );

    always_comb begin
        state_d        = state_q;
        limit_d        = limit_q;
        resp_code_d    = resp_code_q;
        err_code_d     = err_code_q;
        engine_start_d = 1'b0;
        engine_abort_d = 1'b0;
        ctr_clear      = 1'b0;
        drop_count_d   = drop_count_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (is_engine_req(bus.req_type)) begin
                        state_d        = WAIT_ENGINE;
                        engine_start_d = 1'b1;
                        ctr_clear      = 1'b1;
                        limit_d        = (bus.resp_deadline == '0) ? {{(CNT_W-1){1'b0}}, 1'b1}
                                                                   : bus.resp_deadline;
                    end else begin
                        state_d    = SEND_ERR;
                        err_code_d = ERR_INVALID;
                    end
                end
            end
            WAIT_ENGINE: begin
                // A response arriving on the expiry cycle still wins over BUSY.
                if (bus.engine_done) begin
                    resp_code_d = bus.engine_resp_type;
                    state_d     = SEND_RESP;
                end else if (expired) begin
                    err_code_d     = ERR_BUSY;
                    engine_abort_d = 1'b1;
                    state_d        = SEND_ERR;
                end
            end
            SEND_RESP, SEND_ERR: begin
                if (bus.tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.req_valid && (state_q != IDLE) && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end

        tx_valid_d    = (state_d == SEND_RESP) || (state_d == SEND_ERR);
        busy_d        = (state_d != IDLE);
        tx_type_d     = 8'h00;
        tx_err_code_d = 8'h00;
        if (state_d == SEND_RESP) begin
            tx_type_d = resp_code_d;
        end else if (state_d == SEND_ERR) begin
            tx_type_d     = RESP_ERROR;
            tx_err_code_d = err_code_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            limit_q        <= '0;
            resp_code_q    <= 8'h00;
            err_code_q     <= 8'h00;
            engine_start_q <= 1'b0;
            engine_abort_q <= 1'b0;
            tx_valid_q     <= 1'b0;
            tx_type_q      <= 8'h00;
            tx_err_code_q  <= 8'h00;
            busy_q         <= 1'b0;
            drop_count_q   <= 8'h00;
        end else begin
            state_q        <= state_d;
            limit_q        <= limit_d;
            resp_code_q    <= resp_code_d;
            err_code_q     <= err_code_d;
            engine_start_q <= engine_start_d;
            engine_abort_q <= engine_abort_d;
            tx_valid_q     <= tx_valid_d;
            tx_type_q      <= tx_type_d;
            tx_err_code_q  <= tx_err_code_d;
            busy_q         <= busy_d;
            drop_count_q   <= drop_count_d;
        end
    end

    assign bus.engine_start = engine_start_q;
    assign bus.engine_abort = engine_abort_q;
    assign bus.tx_valid     = tx_valid_q;
    assign bus.tx_type      = tx_type_q;
    assign bus.tx_err_code  = tx_err_code_q;
    assign bus.busy         = busy_q;
    assign bus.drop_count   = drop_count_q;
    assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_auth_responder_deadline.sv
// Directed bench: a table of whole transactions plus hand-written stall, drop and reset sequences.
module tb_auth_responder_deadline;
    import auth_defs::*;

    logic clk;
    logic reset_n;
    int   cmp_cnt = 0;
    int   fail_cnt = 0;

    auth_responder_deadline_if #(.CNT_W(32)) bus ();

    auth_responder_deadline #(.CNT_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  req_type;
        logic [31:0] deadline;
        int          done_at;    // cycle index after engine_start cycle; -1 = never
        logic [7:0]  resp_code;
        int          exp_lat;    // cycle index of first tx_valid (0 = cycle after request)
        logic [7:0]  exp_type;
        logic [7:0]  exp_err;
        int          exp_start;
        int          exp_abort;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue_req(input logic [7:0] rtype, input logic [31:0] dl);
        @(posedge clk); #1;
        bus.req_valid     = 1'b1;
        bus.req_type      = rtype;
        bus.resp_deadline = dl;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        int start_cnt = 0;
        int abort_cnt = 0;
        int first = -1;
        logic [7:0] got_type = 8'h00;
        logic [7:0] got_err = 8'h00;
        issue_req(v.req_type, v.deadline);
        for (int t = 0; t < 100 && first < 0; t++) begin
            bus.engine_done      = (t == v.done_at);
            bus.engine_resp_type = v.resp_code;
            @(negedge clk);
            if (bus.engine_start) start_cnt++;
            if (bus.engine_abort) abort_cnt++;
            if (t == 0) check($sformatf("v%0d_busy", idx), {31'd0, bus.busy}, 32'd1);
            if (bus.tx_valid) begin
                first    = t;
                got_type = bus.tx_type;
                got_err  = bus.tx_err_code;
                bus.tx_ready = 1'b1;
            end
            @(posedge clk); #1;
            bus.engine_done = 1'b0;
            bus.tx_ready    = 1'b0;
        end
        @(negedge clk);
        check($sformatf("v%0d_lat", idx), first, v.exp_lat);
        check($sformatf("v%0d_type", idx), {24'd0, got_type}, {24'd0, v.exp_type});
        check($sformatf("v%0d_err", idx), {24'd0, got_err}, {24'd0, v.exp_err});
        check($sformatf("v%0d_start", idx), start_cnt, v.exp_start);
        check($sformatf("v%0d_abort", idx), abort_cnt, v.exp_abort);
        check($sformatf("v%0d_idle", idx), {30'd0, bus.busy, bus.tx_valid}, 32'd0);
    endtask

    initial begin
        int stable_err;
        int seen;

        vecs[0] = '{8'h81, 32'd10, 4, 8'h01, 5, 8'h01, 8'h00, 1, 0};
        vecs[1] = '{8'h82, 32'd5, -1, 8'h00, 6, 8'h7F, 8'h03, 1, 1};
        vecs[2] = '{8'h83, 32'd5, 5, 8'h02, 6, 8'h02, 8'h00, 1, 0};
        vecs[3] = '{8'h90, 32'd7, 0, 8'h11, 0, 8'h7F, 8'h01, 0, 0};
        vecs[4] = '{8'h81, 32'd0, -1, 8'h00, 2, 8'h7F, 8'h03, 1, 1};
        vecs[5] = '{8'h82, 32'd1, 0, 8'h05, 1, 8'h05, 8'h00, 1, 0};
        vecs[6] = '{8'h83, 32'd5, 4, 8'hA5, 5, 8'hA5, 8'h00, 1, 0};
        vecs[7] = '{8'h84, 32'd3, -1, 8'h00, 0, 8'h7F, 8'h01, 0, 0};
        vecs[8] = '{8'h00, 32'd3, -1, 8'h00, 0, 8'h7F, 8'h01, 0, 0};
        vecs[9] = '{8'h81, 32'd3, -1, 8'h00, 4, 8'h7F, 8'h03, 1, 1};

        reset_n              = 1'b0;
        bus.req_valid        = 1'b0;
        bus.req_type         = 8'h00;
        bus.resp_deadline    = 32'd0;
        bus.engine_done      = 1'b0;
        bus.engine_resp_type = 8'h00;
        bus.tx_ready         = 1'b0;
        #12;
        check("rst_outputs", {bus.engine_start, bus.engine_abort, bus.tx_valid, bus.busy},
              32'd0);
        check("rst_payload", {8'd0, bus.tx_type, bus.tx_err_code, bus.drop_count}, 32'd0);
        check("rst_state", {30'd0, bus.state_dbg}, {30'd0, IDLE});
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_txn(i, vecs[i]);
        end
        check("no_drops_yet", {24'd0, bus.drop_count}, 32'd0);

        // Stalled transmitter with ignored requests, the last one on the handshake cycle.
        issue_req(8'h81, 32'd8);
        @(posedge clk); #1;
        bus.engine_done      = 1'b1;
        bus.engine_resp_type = 8'h3C;
        @(posedge clk); #1;
        bus.engine_done = 1'b0;
        @(negedge clk);
        check("stall_tx_up", {31'd0, bus.tx_valid}, 32'd1);
        stable_err = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            bus.req_valid = (i == 3) || (i == 8);
            bus.req_type  = 8'h81;
            @(negedge clk);
            if (!bus.tx_valid || bus.tx_type != 8'h3C || bus.tx_err_code != 8'h00) stable_err++;
        end
        check("stall_stable", stable_err, 32'd0);
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.tx_ready  = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.tx_ready  = 1'b0;
        @(negedge clk);
        check("stall_idle", {30'd0, bus.busy, bus.tx_valid}, 32'd0);
        check("drop_3", {24'd0, bus.drop_count}, 32'd3);

        // Saturation of the drop counter.
        issue_req(8'h90, 32'd0);
        bus.req_valid = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("drop_sat", {24'd0, bus.drop_count}, 32'd255);
        check("sat_err_payload", {16'd0, bus.tx_type, bus.tx_err_code}, 32'h7F01);
        bus.tx_ready = 1'b1;
        @(posedge clk); #1;
        bus.tx_ready = 1'b0;
        @(negedge clk);
        check("sat_idle", {30'd0, bus.busy, bus.tx_valid}, 32'd0);

        // Asynchronous reset while waiting on the engine.
        issue_req(8'h82, 32'd10);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_state", {30'd0, bus.state_dbg}, {30'd0, IDLE});
        check("arst_outputs", {bus.engine_start, bus.engine_abort, bus.tx_valid, bus.busy},
              32'd0);
        check("arst_payload", {8'd0, bus.tx_type, bus.tx_err_code, bus.drop_count}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            bus.engine_done = (i == 0);
            @(negedge clk);
            if (bus.tx_valid || bus.engine_abort || bus.busy || bus.engine_start) seen++;
        end
        bus.engine_done = 1'b0;
        check("arst_quiet", seen, 32'd0);
        run_txn(10, vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench time limit expired");
    end
endmodule

// File: doc/auth_responder_deadline.md
AUTH_RESPONDER_DEADLINE -- requirements
Module: auth_responder_deadline

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the deadline counter and of resp_deadline.
REQ-002 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1: one-cycle pulse, authentication request received.
REQ-005 SHALL have port req_type, input, 8: request code, sampled with req_valid.
REQ-006 SHALL have port resp_deadline, input, CNT_W: cycles allowed for the engine before a BUSY reply; sampled on request acceptance.
REQ-007 SHALL have port engine_start, output, 1: one-cycle pulse to start the crypto engine.
REQ-008 SHALL have port engine_done, input, 1: engine response ready, one-cycle pulse.
REQ-009 SHALL have port engine_resp_type, input, 8: response code, valid with engine_done.
REQ-010 SHALL have port engine_abort, output, 1: one-cycle pulse telling the engine to discard its work.
REQ-011 SHALL have port tx_valid, output, 1: message offered to the transmitter.
REQ-012 SHALL have port tx_ready, input, 1: transmitter accepts when tx_valid and tx_ready are both 1.
REQ-013 SHALL have port tx_type, output, 8: response code to send.
REQ-014 SHALL have port tx_err_code, output, 8: ERROR payload, meaningful only when tx_type is ERROR.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-016 SHALL have port drop_count, output, 8: count of requests ignored because the block was not IDLE; saturates at 255.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT_ENGINE, SEND_RESP, SEND_ERR.
REQ-018 IDLE + req_valid, req_type in {0x81 GET_DIGESTS, 0x82 GET_CERTIFICATE, 0x83 CHALLENGE}:
- latch resp_deadline (0 is treated as 1)
- clear the counter
- next cycle: state WAIT_ENGINE, engine_start=1 for exactly that cycle.
REQ-019 IDLE + req_valid with any other req_type SHALL go to SEND_ERR, code 0x01 (Invalid); no engine_start.
REQ-020 WAIT_ENGINE + engine_done SHALL latch engine_resp_type and go to SEND_RESP, including on the first WAIT_ENGINE cycle.
REQ-021 WAIT_ENGINE without engine_done:
- counter+1 >= latched deadline -> SEND_ERR, code 0x03 (Busy), engine_abort=1 on the transition cycle
- otherwise counter increments.
REQ-022 First tx_valid of a BUSY reply SHALL occur exactly D+1 cycles after the engine_start cycle, where D is the latched deadline.
REQ-023 engine_done on the same cycle as deadline expiry SHALL win: go to SEND_RESP, no engine_abort.
REQ-024 Counter compare SHALL be CNT_W+1 bits wide: no wrap at all-ones.
REQ-025 SEND_RESP SHALL hold tx_valid=1, tx_type=latched engine code, tx_err_code=0, until tx_ready; then IDLE.
REQ-026 SEND_ERR SHALL hold tx_valid=1, tx_type=0x7F (ERROR), tx_err_code=latched code, until tx_ready; then IDLE.
REQ-027 tx_type and tx_err_code SHALL remain stable while tx_valid=1 and tx_ready=0.
REQ-028 req_valid in any non-IDLE state, including the tx handshake cycle, SHALL be ignored and SHALL increment drop_count.
REQ-029 engine_done outside WAIT_ENGINE SHALL be ignored.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 reset_n=0 SHALL immediately force:
- state IDLE
- counter, latched codes and drop_count to 0
- engine_start, engine_abort, tx_valid, busy to 0
- tx_type, tx_err_code to 0x00.
REQ-032 Reset mid-operation SHALL abandon the transaction with no engine_abort and no tx_valid; operation resumes on the first clk edge after deassertion.

Structure
REQ-033 Request codes 0x81-0x83, ERROR 0x7F, error codes Invalid 0x01 / Busy 0x03, and state encodings SHALL live in the shared auth_defs package.
REQ-034 The deadline counter and its expiry compare SHALL be a sub-module, deadline_counter (clear, enable, limit, expired).

Verification
REQ-035 Bench SHALL run: deadline=10, req 0x81, engine_done 4 cycles after engine_start with code 0x01 -> tx_valid with tx_type=0x01, no engine_abort.
REQ-036 Bench SHALL run: deadline=5, no engine_done -> engine_abort pulse, tx_valid 6 cycles after engine_start, tx_type=0x7F, tx_err_code=0x03.
REQ-037 Bench SHALL run: engine_done on the expiry cycle -> SEND_RESP, no abort, no BUSY.
REQ-038 Bench SHALL run: req_type 0x90 -> ERROR 0x01, engine_start never pulses.
REQ-039 Bench SHALL run: tx_ready held low 20 cycles plus 3 extra req_valid pulses -> outputs stable, drop_count=3; then 300 drops -> drop_count=255.
REQ-040 Bench SHALL run: reset_n low during WAIT_ENGINE -> all outputs 0 asynchronously, IDLE after release, no late tx_valid.
